// File: rtl/intr_cpu_pkg.sv
// Shared types and constants for the processor-side interrupt interface:
// FSM state encoding, default vector/EOI prefixes and config-byte formats.
package intr_cpu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG,
    ST_WAIT1,
    ST_ACK1,
    ST_CAP,
    ST_WAIT2,
    ST_ACK2,
    ST_ISR,
    ST_WAIT3,
    ST_EOI,
    ST_HOLD,
    ST_ERR
  } state_e;

  localparam logic [4:0] DEF_VEC_PREFIX = 5'b01011;
  localparam logic [4:0] DEF_EOI_PREFIX = 5'b10100;

  // Controller config bytes: mode byte, and priority byte {prio, id, tag}.
  localparam logic [7:0] CFG_MODE_POLL = 8'h01;
  localparam logic [1:0] CFG_PRIO_TAG  = 2'b10;

  function automatic logic [7:0] cfg_prio_byte(input logic [2:0] prio, input logic [2:0] id);
    return {prio, id, CFG_PRIO_TAG};
  endfunction

endpackage

// File: rtl/intr_cpu_if_if.sv
// Bus bundle between the interrupt controller, this unit and the core.
// Handshakes: a config byte moves on a clock edge where cfg_valid & cfg_ready are both high;
// isr_valid holds the ID until an edge that also sees isr_done; ctl_ack_n pulses are one cycle.
interface intr_cpu_bus_if;
  logic       ctl_intr;
  logic       ctl_bus_oe;
  logic       ctl_ack_n;
  logic [7:0] bus_rd;
  logic [7:0] bus_wr;
  logic       bus_wr_oe;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic       isr_valid;
  logic [2:0] isr_id;
  logic       isr_done;

  modport master (
    input  ctl_intr, ctl_bus_oe, bus_rd, cfg_valid, cfg_data, isr_done,
    output ctl_ack_n, bus_wr, bus_wr_oe, cfg_ready, isr_valid, isr_id
  );

  modport slave (
    output ctl_intr, ctl_bus_oe, bus_rd, cfg_valid, cfg_data, isr_done,
    input  ctl_ack_n, bus_wr, bus_wr_oe, cfg_ready, isr_valid, isr_id
  );
endinterface

// File: rtl/intr_ack_timer.sv
// Reloadable down-counter for the wait states: a load starts ACK_DELAY-1 cycles of
// waiting, done_o pulses in the last waiting cycle and idle_o is high once expired.
module intr_ack_timer #(
  parameter int unsigned ACK_DELAY = 6
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic load_i,
  output logic done_o,
  output logic idle_o
);

  localparam int unsigned TW = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(ACK_DELAY - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == TW'(1));
  assign idle_o = (cnt_q == '0);

endmodule

// File: rtl/intr_cpu_if.sv
// Processor half of the 8-input interrupt controller handshake: config byte writes,
// two acks around vector capture, ISR hand-off to the core, EOI and service counting.
module intr_cpu_if
  import intr_cpu_pkg::*;
#(
  parameter int unsigned ACK_DELAY  = 6,
  parameter logic [4:0]  VEC_PREFIX = DEF_VEC_PREFIX,
  parameter logic [4:0]  EOI_PREFIX = DEF_EOI_PREFIX,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  intr_cpu_bus_if.master   bus,
  output logic             busy,
  output logic             vec_err,
  output logic [CNT_W-1:0] svc_count,
  output state_e           dbg_state_o
);

  localparam bit          SKIP_WAIT = (ACK_DELAY == 1);
  localparam int unsigned TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e             state_q, state_d;
  logic [7:0]         bus_wr_q, bus_wr_d;
  logic [2:0]         isr_id_q, isr_id_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   svc_q, svc_d;

  logic tmr_load, tmr_done, tmr_idle;
  logic ack_n_c, oe_c, cfg_ready_c, isr_valid_c;

  intr_ack_timer #(.ACK_DELAY(ACK_DELAY)) u_timer (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .load_i (tmr_load),
    .done_o (tmr_done),
    .idle_o (tmr_idle)
  );

  always_comb begin
    state_d     = state_q;
    bus_wr_d    = bus_wr_q;
    isr_id_d    = isr_id_q;
    tmo_d       = tmo_q;
    svc_d       = svc_q;
    tmr_load    = 1'b0;
    ack_n_c     = 1'b1;
    oe_c        = 1'b0;
    cfg_ready_c = 1'b0;
    isr_valid_c = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_CFG: begin
        // The controller grabbing the bus while we drive a config byte is fatal.
        if (state_q == ST_CFG && bus.ctl_bus_oe) begin
          state_d = ST_ERR;
        end else begin
          oe_c        = (state_q == ST_CFG);
          cfg_ready_c = !bus.ctl_intr && !bus.ctl_bus_oe;
          if (bus.ctl_intr) begin
            state_d  = SKIP_WAIT ? ST_ACK1 : ST_WAIT1;
            tmr_load = 1'b1;
          end else if (bus.cfg_valid && cfg_ready_c) begin
            state_d  = ST_CFG;
            bus_wr_d = bus.cfg_data;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT1: if (tmr_done) state_d = ST_ACK1;
      ST_ACK1: begin
        ack_n_c = 1'b0;
        tmo_d   = '0;
        state_d = ST_CAP;
      end
      ST_CAP: begin
        if (bus.ctl_bus_oe) begin
          if (bus.bus_rd[7:3] == VEC_PREFIX) begin
            isr_id_d = bus.bus_rd[2:0];
            state_d  = SKIP_WAIT ? ST_ACK2 : ST_WAIT2;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_ERR;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_WAIT2: if (tmr_done) state_d = ST_ACK2;
      ST_ACK2: begin
        ack_n_c = 1'b0;
        state_d = ST_ISR;
      end
      ST_ISR: begin
        isr_valid_c = 1'b1;
        if (bus.isr_done) begin
          tmr_load = 1'b1;
          if (SKIP_WAIT && !bus.ctl_bus_oe) begin
            state_d  = ST_EOI;
            bus_wr_d = {EOI_PREFIX, isr_id_q};
          end else begin
            state_d = ST_WAIT3;
          end
        end
      end
      ST_WAIT3: begin
        // Delay elapsed, but never start EOI while the controller still owns the bus.
        if ((tmr_done || tmr_idle) && !bus.ctl_bus_oe) begin
          state_d  = ST_EOI;
          bus_wr_d = {EOI_PREFIX, isr_id_q};
        end
      end
      ST_EOI: begin
        if (bus.ctl_bus_oe) begin
          state_d = ST_ERR;
        end else begin
          oe_c    = 1'b1;
          ack_n_c = 1'b0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.ctl_bus_oe) begin
          state_d = ST_ERR;
        end else begin
          oe_c    = 1'b1;
          svc_d   = svc_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      bus_wr_q <= '0;
      isr_id_q <= '0;
      tmo_q    <= '0;
      svc_q    <= '0;
    end else begin
      state_q  <= state_d;
      bus_wr_q <= bus_wr_d;
      isr_id_q <= isr_id_d;
      tmo_q    <= tmo_d;
      svc_q    <= svc_d;
    end
  end

  assign bus.ctl_ack_n = ack_n_c;
  assign bus.bus_wr_oe = oe_c;
  assign bus.bus_wr    = oe_c ? bus_wr_q : 8'h00;
  assign bus.cfg_ready = cfg_ready_c && !rst_in;
  assign bus.isr_valid = isr_valid_c;
  assign bus.isr_id    = isr_id_q;

  assign busy        = (state_q != ST_IDLE);
  assign vec_err     = (state_q == ST_ERR);
  assign svc_count   = svc_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_intr_cpu_if.sv
// Bench for intr_cpu_if: a controller/core model drives randomized traffic, pushes the
// expected bus events (ack pulses, driven bytes, ISR hand-offs) with cycle stamps into a queue.
module tb_intr_cpu_if;
  import intr_cpu_pkg::*;

  localparam int         ACK_DELAY = 6;
  localparam int         TIMEOUT   = 255;
  localparam int         CNT_W     = 8;
  localparam logic [4:0] VEC       = 5'b01011;
  localparam logic [4:0] EOIP      = 5'b10100;
  localparam int         EW        = 26;
  localparam logic [1:0] K_ACK     = 2'd1;
  localparam logic [1:0] K_WR      = 2'd2;
  localparam logic [1:0] K_ISR     = 2'd3;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic             busy;
  logic             vec_err;
  logic [CNT_W-1:0] svc_count;
  state_e           dbg_state;

  intr_cpu_bus_if bus_if ();

  intr_cpu_if #(
    .ACK_DELAY (ACK_DELAY),
    .VEC_PREFIX(VEC),
    .EOI_PREFIX(EOIP),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .bus        (bus_if.master),
    .busy       (busy),
    .vec_err    (vec_err),
    .svc_count  (svc_count),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  initial forever begin
    @(posedge clk_in);
    cyc = cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog no completion by time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int overlaps = 0;
  int exp_svc  = 0;

  function automatic logic [EW-1:0] ev(input logic [1:0] k, input logic [7:0] d, input int c);
    return {k, d, 16'(c)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic sb_compare(input logic [EW-1:0] obs);
    logic [EW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected actual kind=%0d data=%02h cyc=%0d required=none",
               obs[25:24], obs[23:16], obs[15:0]);
    end else begin
      e = exp_q.pop_front();
      if (e !== obs) begin
        failures++;
        $display("FAIL sb_event actual kind=%0d data=%02h cyc=%0d required kind=%0d data=%02h cyc=%0d",
                 obs[25:24], obs[23:16], obs[15:0], e[25:24], e[23:16], e[15:0]);
      end
    end
  endtask

  // Monitor: turns DUT bus activity into time-stamped events.
  initial begin
    logic prev_isr;
    prev_isr = 1'b0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        prev_isr = 1'b0;
      end else begin
        if (bus_if.bus_wr_oe && bus_if.ctl_bus_oe) overlaps++;
        if (!bus_if.ctl_ack_n) sb_compare(ev(K_ACK, 8'h00, cyc));
        if (bus_if.bus_wr_oe) sb_compare(ev(K_WR, bus_if.bus_wr, cyc));
        if (bus_if.isr_valid && !prev_isr) sb_compare(ev(K_ISR, {5'b0, bus_if.isr_id}, cyc));
        prev_isr = bus_if.isr_valid;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic apply_reset();
    rst_in = 1'b1;
    #1;
    check("rst_ack_n", bus_if.ctl_ack_n, 1);
    check("rst_wr_oe", bus_if.bus_wr_oe, 0);
    check("rst_bus_wr", bus_if.bus_wr, 0);
    check("rst_cfg_ready", bus_if.cfg_ready, 0);
    check("rst_isr_valid", bus_if.isr_valid, 0);
    check("rst_isr_id", bus_if.isr_id, 0);
    check("rst_busy", busy, 0);
    check("rst_vec_err", vec_err, 0);
    check("rst_svc_count", svc_count, 0);
    check("rst_state", dbg_state, ST_IDLE);
    bus_if.ctl_intr   = 1'b0;
    bus_if.ctl_bus_oe = 1'b0;
    bus_if.cfg_valid  = 1'b0;
    bus_if.isr_done   = 1'b0;
    tick(2);
    rst_in  = 1'b0;
    exp_svc = 0;
  endtask

  // One config byte: exactly one cycle of cfg_valid; byte appears on the bus next cycle.
  task automatic cfg_byte(input logic [7:0] b);
    bus_if.cfg_valid = 1'b1;
    bus_if.cfg_data  = b;
    exp_q.push_back(ev(K_WR, b, cyc + 1));
    @(negedge clk_in);
    check("cfg_ready_burst", bus_if.cfg_ready, 1);
    tick(1);
  endtask

  task automatic cfg_idle();
    bus_if.cfg_valid = 1'b0;
    tick(2);
  endtask

  // Start an interrupt in the current cycle; first ack due ACK_DELAY cycles later.
  task automatic raise_intr(output int t, input bit sim);
    t = cyc;
    bus_if.ctl_intr = 1'b1;
    exp_q.push_back(ev(K_ACK, 8'h00, t + ACK_DELAY));
    if (sim) begin
      bus_if.cfg_valid = 1'b1;
      bus_if.cfg_data  = 8'($urandom);
      @(negedge clk_in);
      check("cfg_ready_vs_intr", bus_if.cfg_ready, 0);
      tick(1);
      bus_if.cfg_valid = 1'b0;
    end
  endtask

  task automatic drive_vector(input int tc, input logic [7:0] v);
    tick_to(tc);
    bus_if.ctl_bus_oe = 1'b1;
    bus_if.bus_rd     = v;
    tick(1);
    bus_if.ctl_bus_oe = 1'b0;
    bus_if.bus_rd     = 8'($urandom);
  endtask

  task automatic service(input logic [2:0] id, input int k, input int d, input bit guard,
                         input bit spurious, input bit sim);
    int t, tc, td, gs, gl, e;
    raise_intr(t, sim);
    tick_to(t + $urandom_range(1, 7));
    bus_if.ctl_intr = 1'b0;
    tc = t + ACK_DELAY + k;
    exp_q.push_back(ev(K_ACK, 8'h00, tc + ACK_DELAY));
    exp_q.push_back(ev(K_ISR, {5'b0, id}, tc + ACK_DELAY + 1));
    drive_vector(tc, {VEC, id});
    if (spurious) begin
      tick_to(tc + 2);
      bus_if.isr_done = 1'b1;
      tick(1);
      bus_if.isr_done = 1'b0;
    end
    td = tc + ACK_DELAY + 1 + d;
    tick_to(td);
    bus_if.isr_done = 1'b1;
    tick(1);
    bus_if.isr_done = 1'b0;
    // EOI follows the delay, pushed back while the controller holds the bus.
    e = td + ACK_DELAY;
    if (guard) begin
      gs = td + $urandom_range(2, ACK_DELAY - 1);
      gl = $urandom_range(1, 3);
      if (gs + gl - 1 >= td + ACK_DELAY - 1) e = gs + gl + 1;
      tick_to(gs);
      bus_if.ctl_bus_oe = 1'b1;
      tick(gl);
      bus_if.ctl_bus_oe = 1'b0;
    end
    exp_q.push_back(ev(K_ACK, 8'h00, e));
    exp_q.push_back(ev(K_WR, {EOIP, id}, e));
    exp_q.push_back(ev(K_WR, {EOIP, id}, e + 1));
    exp_svc++;
    tick_to(e + 2);
    check("svc_count", svc_count, 32'(exp_svc % (1 << CNT_W)));
    check("busy_after_svc", busy, 0);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int t, tc, n;
    logic [2:0] ids[4];
    bus_if.ctl_intr   = 1'b0;
    bus_if.ctl_bus_oe = 1'b0;
    bus_if.bus_rd     = 8'h00;
    bus_if.cfg_valid  = 1'b0;
    bus_if.cfg_data   = 8'h00;
    bus_if.isr_done   = 1'b0;
    #2;
    apply_reset();
    tick(1);

    cfg_byte(8'hAE);
    cfg_byte(8'hE2);
    cfg_byte(8'h8A);
    cfg_byte(8'hC6);
    cfg_idle();
    cfg_byte(CFG_MODE_POLL);
    cfg_idle();
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) cfg_byte(cfg_prio_byte(3'($urandom), 3'($urandom)));
      cfg_idle();
    end

    service(3'd3, 1, 3, 1'b0, 1'b0, 1'b0);
    service(3'd7, $urandom_range(1, 4), $urandom_range(0, 3), 1'b0, 1'b0, 1'b1);

    ids[0] = 3'd7; ids[1] = 3'd5; ids[2] = 3'd3; ids[3] = 3'd1;
    for (int s = 0; s < 8; s++) begin
      service(ids[s % 4], $urandom_range(1, 4), $urandom_range(0, 3),
              1'($urandom), 1'($urandom), 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        cfg_byte(8'($urandom));
        cfg_idle();
      end
    end

    // Reset while the core holds an ID.
    raise_intr(t, 1'b0);
    tick_to(t + ACK_DELAY + 1);
    bus_if.ctl_intr = 1'b0;
    tc = t + ACK_DELAY + 1;
    exp_q.push_back(ev(K_ACK, 8'h00, tc + ACK_DELAY));
    exp_q.push_back(ev(K_ISR, 8'h06, tc + ACK_DELAY + 1));
    drive_vector(tc, {VEC, 3'd6});
    tick_to(tc + ACK_DELAY + 3);
    check("isr_valid_pre_reset", bus_if.isr_valid, 1);
    #2;
    apply_reset();
    tick(1);

    // Bad vector prefix: error is sticky, second ack never comes.
    raise_intr(t, 1'b0);
    tick_to(t + ACK_DELAY + 1);
    bus_if.ctl_intr = 1'b0;
    drive_vector(t + ACK_DELAY + 1, 8'b11111_010);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      bus_if.cfg_valid = 1'b1;
      bus_if.cfg_data  = 8'($urandom);
      bus_if.ctl_intr  = 1'($urandom);
      #1;
      check("err_vec_err", vec_err, 1);
      check("err_cfg_ready", bus_if.cfg_ready, 0);
    end
    check("err_state", dbg_state, ST_ERR);
    bus_if.cfg_valid = 1'b0;
    bus_if.ctl_intr  = 1'b0;
    tick(1);
    #1;
    apply_reset();
    tick(1);

    // No vector ever offered: error after TIMEOUT capture cycles.
    raise_intr(t, 1'b0);
    tick_to(t + ACK_DELAY + TIMEOUT);
    check("tmo_vec_err_before", vec_err, 0);
    tick(1);
    check("tmo_vec_err_after", vec_err, 1);
    bus_if.ctl_intr = 1'b0;
    tick(2);
    #1;
    apply_reset();
    tick(1);

    service(3'($urandom), $urandom_range(1, 4), $urandom_range(0, 3), 1'b1, 1'b0, 1'b0);
    tick(4);

    check("exp_q_empty", exp_q.size(), 0);
    check("oe_overlap", overlaps, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intr_cpu_if.md
Name: intr_cpu_if

Overview:
- Processor-side interrupt interface unit. It sits directly downstream of the 8-input interrupt controller and consumes its intr_out / bus_oe / vector bus.
- It performs the processor half of the handshake:
  - issues configuration bytes,
  - acknowledges the interrupt,
  - captures and checks the vector,
  - acknowledges the address,
  - hands the ID to the core,
  - issues end-of-interrupt (EOI).
- Synthesizable replacement for the processor behaviour currently modelled only in the testbench.

Parameters:
- ACK_DELAY, 6: cycles between the triggering event and each ack pulse (min 1).
- VEC_PREFIX, 5'b01011: required value of vector bits [7:3].
- EOI_PREFIX, 5'b10100: bits [7:3] driven with the ID at EOI.
- TIMEOUT, 255: maximum cycles to wait for ctl_bus_oe in CAP.
- CNT_W, 8: width of svc_count.

Ports:
- clk_in, in, 1: system clock, rising edge.
- rst_in, in, 1: reset, asynchronous, active-high.
- ctl_intr, in, 1: controller intr_out.
- ctl_bus_oe, in, 1: controller is driving the shared bus.
- ctl_ack_n, out, 1: to controller intr_in; active-low one-cycle pulses.
- bus_rd, in, 8: shared bus read value.
- bus_wr, out, 8: value this block drives onto the shared bus.
- bus_wr_oe, out, 1: tristate enable for bus_wr at top level.
- cfg_valid, in, 1: core requests a config byte write.
- cfg_data, in, 8: config byte.
- cfg_ready, out, 1: config byte accepted this cycle.
- isr_valid, out, 1: ID presented to the core.
- isr_id, out, 3: interrupt ID being serviced.
- isr_done, in, 1: core finished the ISR.
- busy, out, 1: not in IDLE.
- vec_err, out, 1: sticky; bad prefix or timeout.
- svc_count, out, CNT_W: completed services, wraps at 2^CNT_W.

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - ctl_ack_n=1, bus_wr=0, bus_wr_oe=0, cfg_ready=0, isr_valid=0, isr_id=0, busy=0, vec_err=0, svc_count=0, counters=0.
- States: IDLE, CFG, WAIT1, ACK1, CAP, WAIT2, ACK2, ISR, WAIT3, EOI, HOLD, ERR.
- cfg_ready:
  - Asserted combinationally when (IDLE or CFG) and ctl_intr=0 and ctl_bus_oe=0.
  - A transfer is cfg_valid & cfg_ready at the edge. It registers bus_wr=cfg_data and bus_wr_oe=1 for exactly the next cycle (state CFG).
  - Back-to-back transfers give one byte per cycle.
  - CFG with no new transfer returns to IDLE with oe=0.
- Interrupt path:
  - IDLE/CFG with ctl_intr=1 at the edge: go to WAIT1 and load the counter. ctl_intr has priority over cfg_valid.
  - WAIT1: count ACK_DELAY-1 cycles, then ACK1. ACK1 begins ACK_DELAY cycles after ctl_intr was sampled.
  - ACK1: ctl_ack_n=0 for one cycle, then CAP.
  - CAP: first cycle with ctl_bus_oe=1, sample bus_rd.
    - If [7:3]==VEC_PREFIX: isr_id<=bus_rd[2:0], go to WAIT2.
    - Otherwise go to ERR.
    - After TIMEOUT cycles with no ctl_bus_oe: go to ERR.
  - WAIT2 (ACK_DELAY-1 cycles), then ACK2: ctl_ack_n=0 for one cycle, then ISR.
  - ISR: isr_valid=1 until sampled with isr_done=1. isr_done outside ISR is ignored. Then WAIT3.
  - WAIT3: count ACK_DELAY-1 cycles. Additionally hold while ctl_bus_oe=1 (contention guard). Then EOI.
  - EOI: bus_wr={EOI_PREFIX,isr_id}, bus_wr_oe=1, ctl_ack_n=0, one cycle.
  - HOLD: bus_wr/bus_wr_oe held one more cycle, ctl_ack_n=1, svc_count+1, then IDLE.
- ERR: vec_err=1, all handshake outputs idle, cfg_ready=0. Leaves only on reset.
- Invariant: bus_wr_oe=1 never coincides with ctl_bus_oe=1.
  - In CFG/EOI, if ctl_bus_oe rises unexpectedly, drop oe that cycle and go to ERR.
- ctl_intr dropping after WAIT1 entry does not abort; the sequence completes and relies on the controller timeout/behaviour.
- busy = (state != IDLE).

Decomposition:
- Package intr_cpu_pkg holds:
  - state enum,
  - default VEC_PREFIX / EOI_PREFIX,
  - config-byte format constants (mode byte 8'h01 = polling; priority byte {prio[2:0], id[2:0], 2'b10}).
- One sub-module, intr_ack_timer: load, count ACK_DELAY, single-cycle done pulse. It is reused for WAIT1/2/3.

Test Plan:
- Reset mid-ISR (assert rst_in while isr_valid=1) -> same cycle: ctl_ack_n=1, bus_wr_oe=0, isr_valid=0, svc_count=0.
- Config: cfg_data 8'hAE, 8'hE2, 8'h8A, 8'hC6 back-to-back, ctl_intr=0 -> bus_wr shows each byte for one cycle each with oe=1, cfg_ready high all four cycles.
- Polling service:
  - Stimulus: ctl_intr rises; controller model drives 8'b01011_011 on bus_rd with ctl_bus_oe=1 after ack; isr_done 3 cycles later.
  - Required: ctl_ack_n low exactly 6 cycles after ctl_intr; second ack 6 cycles after capture; isr_id=3; EOI drives 8'b10100_011 with ctl_ack_n=0; svc_count=1.
- Bad vector: bus_rd=8'b11111_010 at capture -> vec_err=1 sticky, no ACK2, stays in ERR until reset.
- Timeout: ctl_intr high, ctl_bus_oe never asserted -> vec_err=1 after 255 CAP cycles.
- Simultaneous cfg_valid and ctl_intr in IDLE -> interrupt taken, cfg_ready=0, no config byte driven; eight sequential services with IDs 7,5,3,1 -> svc_count increments, bus_wr_oe never overlaps ctl_bus_oe.
